wb_write_arbiter: RTL and testbench
===================================

// Module: wb_write_arbiter
// PURPOSE
//  Write-back arbiter directly upstream of registerFile: the sole driver of its single write port (we, writeRegister, writeData).
//  Merges in-order pipeline write-back with results from the multi-cycle mul/div unit, which are buffered in a small FIFO.
//  Pipeline write-back has priority; a starvation counter forces a one-cycle pipeline bubble to drain the FIFO.
//  Exports a pending-register mask so the hazard unit can hold WAW/RAW on registers with queued results.
// PARAMETERS
//  DEPTH         2   mul/div result FIFO entries; power of 2, >=2
//  STARVE_LIMIT  4   consecutive cycles FIFO head may be denied before stallReq; >=1
// PORTS
//  clk            in   1   clock, all state updates on posedge
//  rst            in   1   asynchronous active-low reset
//  wbValid        in   1   pipeline write-back valid this cycle
//  wbReg          in   5   pipeline destination register
//  wbData         in   32  pipeline write data
//  mdValid        in   1   mul/div result offered
//  mdReady        out  1   FIFO can accept (= !full); transfer when mdValid&&mdReady
//  mdReg          in   5   mul/div destination register
//  mdData         in   32  mul/div result
//  we             out  1   register-file write enable
//  writeRegister  out  5   register-file write address
//  writeData      out  32  register-file write data
//  stallReq       out  1   registered; hazard unit must present wbValid=0 this cycle
//  busyMask       out  32  bit r set while any FIFO entry targets r (bit 0 always 0)
//  protocolErr    out  1   sticky: wbValid seen while stallReq=1
// BEHAVIOUR
//  Reset (rst=0, asynchronous): FIFO empty, pointers/count 0, starve counter 0, state IDLE, stallReq=0, protocolErr=0.
//   Reset mid-operation discards queued results; after reset mdReady=1, busyMask=0, we=0.
//  Write port is combinational from current inputs/FIFO head; registerFile captures on the same edge.
//   Grant: stallReq ? FIFO head : wbValid ? pipeline : FIFO head if non-empty, else none.
//   we = granted && dest!=0; a granted FIFO entry with dest 0 is still popped (write dropped).
//   Pipeline write wins even when stallReq=1 with wbValid=1; protocolErr then set until reset.
//  FIFO: push on mdValid&&mdReady, pop when FIFO head granted; push+pop same cycle allowed (count unchanged).
//   No empty bypass: a mul/div result reaches the register file no earlier than 1 cycle after acceptance.
//   Full: mdReady=0; push ignored even if pop occurs same cycle (ready is !full of current state).
//   Pointers wrap modulo DEPTH; count is 0..DEPTH inclusive.
//  busyMask: OR of one-hot(dest) over valid entries, combinational from FIFO state; bit 0 forced 0.
//   Ordering vs. pipeline writes to the same register is NOT checked here; the hazard unit holds
//   any instruction whose destination or source hits busyMask.
//  FSM (state: IDLE, PEND, STALL):
//   IDLE  : FIFO empty; starve=0. -> PEND when a push occurs.
//   PEND  : FIFO non-empty. If head granted: starve=0; -> IDLE if count becomes 0.
//           If denied (pipeline wins): starve+1; when starve reaches STARVE_LIMIT -> STALL (starve=0).
//   STALL : stallReq=1 for exactly one cycle; head granted (popped) that cycle.
//           -> PEND if entries remain, else IDLE.
//  stallReq is a decoded state output (state==STALL), glitch-free.
// STRUCTURE
//  Shared package: FSM state encoding, REG_W=5, DATA_W=32, REG_ZERO=5'd0.
//  One sub-module: wb_result_fifo (DEPTH-entry reg/data FIFO, exposes head, count, per-entry valid/dest
//   for busyMask). Arbiter FSM, starve counter, grant mux and protocolErr live in the top.
// TESTING
//  1 Reset: pulse rst low mid-cycle with 2 entries queued -> immediately we=0, mdReady=1, busyMask=0, stallReq=0.
//  2 Pipeline only: wbValid=1, wbReg=5, wbData=32'hDEAD_BEEF -> same cycle we=1, writeRegister=5, writeData=DEADBEEF.
//  3 $0 drop: wbReg=0, and md result to reg 0 -> we=0 both times; FIFO count returns to 0.
//  4 Fill: two md pushes (reg 8, reg 9) while wbValid=1 -> mdReady=0, busyMask=32'h300; third offer held.
//  5 Starvation: FIFO holds reg 8, wbValid=1 for 4 cycles -> stallReq=1 in cycle 5, writes reg 8,
//    busyMask bit 8 clears next cycle; driving wbValid=1 during stallReq sets protocolErr.
//  6 Idle drain: FIFO holds 7:=1, 9:=2, wbValid=0 -> two consecutive writes in order 7 then 9, then IDLE.

Source files
------------

// File: rtl/wb_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package wb_write_arbiter_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    StIdle,
    StPend,
    StStall
  } arb_state_e;

  // One-hot decode of a register index, used to build the busy mask.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
    reg_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << r;
  endfunction

endpackage

// File: rtl/wb_write_arbiter_result_fifo.sv
// DEPTH-entry FIFO of mul/div results (destination register + data). Exposes the head, the
// occupancy and per-entry valid/destination so the top can build the busy mask.
module wb_result_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  logic [REG_W-1:0]              push_reg_i,
  input  logic [DATA_W-1:0]             push_data_i,
  input  logic                          pop_i,
  output logic [REG_W-1:0]              head_reg_o,
  output logic [DATA_W-1:0]             head_data_o,
  output logic [CntW-1:0]               count_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [DEPTH-1:0]              entry_valid_o,
  output logic [DEPTH-1:0][REG_W-1:0]   entry_reg_o
);

  logic [REG_W-1:0]  mem_reg_q  [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              push, pop;
  logic [PtrW-1:0]   offs;

  assign full_o      = (count_q == CntW'(DEPTH));
  assign empty_o     = (count_q == '0);
  // Full is judged on the current state, so a same-cycle pop never frees room for a push.
  assign push        = push_i && !full_o;
  assign pop         = pop_i && !empty_o;
  assign head_reg_o  = mem_reg_q[rd_ptr_q];
  assign head_data_o = mem_data_q[rd_ptr_q];
  assign count_o     = count_q;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg_q[i]  <= REG_ZERO;
        mem_data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_reg_q[wr_ptr_q]  <= push_reg_i;
        mem_data_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // An entry is live if its distance from the read pointer is below the occupancy.
  always_comb begin
    offs = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs             = PtrW'(i) - rd_ptr_q;
      entry_valid_o[i] = ({1'b0, offs} < count_q);
      entry_reg_o[i]   = mem_reg_q[i];
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Sole driver of the register-file write port. Pipeline write-back has priority; mul/div results
// wait in a FIFO and a starvation counter forces a one-cycle pipeline bubble to drain them.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wbValid,
  input  logic [REG_W-1:0]    wbReg,
  input  logic [DATA_W-1:0]   wbData,
  input  logic                mdValid,
  output logic                mdReady,
  input  logic [REG_W-1:0]    mdReg,
  input  logic [DATA_W-1:0]   mdData,
  output logic                we,
  output logic [REG_W-1:0]    writeRegister,
  output logic [DATA_W-1:0]   writeData,
  output logic                stallReq,
  output logic [NUM_REGS-1:0] busyMask,
  output logic                protocolErr
);

  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  logic                        fifo_full, fifo_empty;
  logic [CntW-1:0]             fifo_count, cnt_after;
  logic [REG_W-1:0]            head_reg;
  logic [DATA_W-1:0]           head_data;
  logic [DEPTH-1:0]            entry_valid;
  logic [DEPTH-1:0][REG_W-1:0] entry_reg;
  logic                        md_push, fifo_grant;
  arb_state_e                  state_q;
  logic [StarveW-1:0]          starve_q;
  logic                        prot_err_q;

  assign mdReady  = !fifo_full;
  assign md_push  = mdValid && mdReady;
  // A stall cycle also lands here: the pipeline still wins if it violates the stall.
  assign fifo_grant  = !wbValid && !fifo_empty;
  assign stallReq    = (state_q == StStall);
  assign protocolErr = prot_err_q;

  wb_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i         (clk),
    .rst_ni        (rst),
    .push_i        (md_push),
    .push_reg_i    (mdReg),
    .push_data_i   (mdData),
    .pop_i         (fifo_grant),
    .head_reg_o    (head_reg),
    .head_data_o   (head_data),
    .count_o       (fifo_count),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .entry_valid_o (entry_valid),
    .entry_reg_o   (entry_reg)
  );

  // Write-port mux; writes to $0 are granted (and popped) but never enabled.
  always_comb begin
    we            = 1'b0;
    writeRegister = REG_ZERO;
    writeData     = '0;
    if (wbValid) begin
      writeRegister = wbReg;
      writeData     = wbData;
      we            = (wbReg != REG_ZERO);
    end else if (fifo_grant) begin
      writeRegister = head_reg;
      writeData     = head_data;
      we            = (head_reg != REG_ZERO);
    end
  end

  // Occupancy after this edge, used to decide when the FSM returns to idle.
  always_comb begin
    cnt_after = fifo_count;
    if (md_push && !fifo_grant) begin
      cnt_after = fifo_count + 1'b1;
    end else if (!md_push && fifo_grant) begin
      cnt_after = fifo_count - 1'b1;
    end
  end

  // Registers with results still queued; $0 never needs protecting.
  always_comb begin
    busyMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        busyMask = busyMask | reg_onehot(entry_reg[i]);
      end
    end
    busyMask[0] = 1'b0;
  end

  // Arbiter FSM, starvation counter and sticky protocol-error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      starve_q   <= '0;
      prot_err_q <= 1'b0;
    end else begin
      if (state_q == StStall && wbValid) begin
        prot_err_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          starve_q <= '0;
          if (md_push) state_q <= StPend;
        end
        StPend: begin
          if (fifo_grant) begin
            starve_q <= '0;
            if (cnt_after == '0) state_q <= StIdle;
          end else if (starve_q == StarveW'(STARVE_LIMIT - 1)) begin
            starve_q <= '0;
            state_q  <= StStall;
          end else begin
            starve_q <= starve_q + 1'b1;
          end
        end
        StStall: begin
          starve_q <= '0;
          state_q  <= (cnt_after == '0) ? StIdle : StPend;
        end
        default: begin
          starve_q <= '0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wbValid = 1'b0;
  logic [4:0]  wbReg = '0;
  logic [31:0] wbData = '0;
  logic        mdValid = 1'b0;
  logic        mdReady;
  logic [4:0]  mdReg = '0;
  logic [31:0] mdData = '0;
  logic        we;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic        stallReq;
  logic [31:0] busyMask;
  logic        protocolErr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_write_arbiter #(
    .DEPTH        (2),
    .STARVE_LIMIT (4)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .wbValid       (wbValid),
    .wbReg         (wbReg),
    .wbData        (wbData),
    .mdValid       (mdValid),
    .mdReady       (mdReady),
    .mdReg         (mdReg),
    .mdData        (mdData),
    .we            (we),
    .writeRegister (writeRegister),
    .writeData     (writeData),
    .stallReq      (stallReq),
    .busyMask      (busyMask),
    .protocolErr   (protocolErr)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (we !== 1'b0) begin fails++; $display("FAIL rst_we: got %0b want 0", we); end
    tests++; if (mdReady !== 1'b1) begin fails++; $display("FAIL rst_mdReady: got %0b want 1", mdReady); end
    tests++; if (busyMask !== 32'h0) begin fails++; $display("FAIL rst_busy: got %h want 0", busyMask); end
    tests++; if (stallReq !== 1'b0) begin fails++; $display("FAIL rst_stall: got %0b want 0", stallReq); end
    tests++; if (protocolErr !== 1'b0) begin fails++; $display("FAIL rst_perr: got %0b want 0", protocolErr); end
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_pipeline();
    wbValid = 1'b1; wbReg = 5'd5; wbData = 32'hDEAD_BEEF;
    @(negedge clk);
    tests++; if (we !== 1'b1) begin fails++; $display("FAIL pipe_we: got %0b want 1", we); end
    tests++; if (writeRegister !== 5'd5) begin fails++; $display("FAIL pipe_reg: got %0d want 5", writeRegister); end
    tests++; if (writeData !== 32'hDEAD_BEEF) begin fails++; $display("FAIL pipe_data: got %h want deadbeef", writeData); end
    next_cycle();
    wbValid = 1'b0;
  endtask

  task automatic test_zero_drop();
    wbValid = 1'b1; wbReg = 5'd0; wbData = 32'h1234;
    @(negedge clk);
    tests++; if (we !== 1'b0) begin fails++; $display("FAIL zero_pipe_we: got %0b want 0", we); end
    next_cycle();
    wbValid = 1'b0; mdValid = 1'b1; mdReg = 5'd0; mdData = 32'h5678;
    @(negedge clk);
    tests++; if (we !== 1'b0) begin fails++; $display("FAIL zero_nobypass_we: got %0b want 0", we); end
    next_cycle();
    mdValid = 1'b0;
    @(negedge clk);
    tests++; if (we !== 1'b0) begin fails++; $display("FAIL zero_md_we: got %0b want 0", we); end
    tests++; if (busyMask !== 32'h0) begin fails++; $display("FAIL zero_busy: got %h want 0", busyMask); end
    next_cycle();
    @(negedge clk);
    tests++; if (we !== 1'b0) begin fails++; $display("FAIL zero_after_we: got %0b want 0", we); end
    tests++; if (mdReady !== 1'b1) begin fails++; $display("FAIL zero_after_rdy: got %0b want 1", mdReady); end
    next_cycle();
  endtask

  task automatic test_fill();
    wbValid = 1'b1; wbReg = 5'd1; wbData = 32'h11;
    mdValid = 1'b1; mdReg = 5'd8; mdData = 32'h80;
    @(negedge clk);
    tests++; if (writeRegister !== 5'd1) begin fails++; $display("FAIL fill_pipe_reg: got %0d want 1", writeRegister); end
    next_cycle();
    wbReg = 5'd2; mdReg = 5'd9; mdData = 32'h90;
    @(negedge clk);
    tests++; if (mdReady !== 1'b1) begin fails++; $display("FAIL fill_rdy1: got %0b want 1", mdReady); end
    tests++; if (busyMask !== 32'h100) begin fails++; $display("FAIL fill_busy1: got %h want 100", busyMask); end
    next_cycle();
    wbReg = 5'd3; mdReg = 5'd10; mdData = 32'hA0;
    @(negedge clk);
    tests++; if (mdReady !== 1'b0) begin fails++; $display("FAIL fill_rdy_full: got %0b want 0", mdReady); end
    tests++; if (busyMask !== 32'h300) begin fails++; $display("FAIL fill_busy_full: got %h want 300", busyMask); end
    tests++; if (writeRegister !== 5'd3) begin fails++; $display("FAIL fill_pipe_reg3: got %0d want 3", writeRegister); end
    next_cycle();
    // Pipeline idle: drain while the third result keeps being offered.
    wbValid = 1'b0;
    @(negedge clk);
    tests++; if (we !== 1'b1 || writeRegister !== 5'd8 || writeData !== 32'h80) begin
      fails++; $display("FAIL fill_drain8: got we=%0b r=%0d d=%h want 1/8/80", we, writeRegister, writeData); end
    tests++; if (mdReady !== 1'b0) begin fails++; $display("FAIL fill_rdy_popfull: got %0b want 0", mdReady); end
    next_cycle();
    @(negedge clk);
    tests++; if (we !== 1'b1 || writeRegister !== 5'd9 || writeData !== 32'h90) begin
      fails++; $display("FAIL fill_drain9: got we=%0b r=%0d d=%h want 1/9/90", we, writeRegister, writeData); end
    tests++; if (busyMask !== 32'h200) begin fails++; $display("FAIL fill_busy9: got %h want 200", busyMask); end
    next_cycle();
    mdValid = 1'b0;
    @(negedge clk);
    tests++; if (we !== 1'b1 || writeRegister !== 5'd10 || writeData !== 32'hA0) begin
      fails++; $display("FAIL fill_drain10: got we=%0b r=%0d d=%h want 1/10/a0", we, writeRegister, writeData); end
    tests++; if (busyMask !== 32'h400) begin fails++; $display("FAIL fill_busy10: got %h want 400", busyMask); end
    next_cycle();
    @(negedge clk);
    tests++; if (we !== 1'b0 || busyMask !== 32'h0) begin
      fails++; $display("FAIL fill_empty: got we=%0b busy=%h want 0/0", we, busyMask); end
    next_cycle();
  endtask

  task automatic test_starvation();
    // Cycle 0: accept reg 8 while the pipeline writes.
    wbValid = 1'b1; wbReg = 5'd1; wbData = 32'h1;
    mdValid = 1'b1; mdReg = 5'd8; mdData = 32'h88;
    next_cycle();
    mdValid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wbReg = 5'(i + 1); wbData = 32'(i);
      @(negedge clk);
      tests++; if (stallReq !== 1'b0) begin fails++; $display("FAIL starve_nostall%0d: got %0b want 0", i, stallReq); end
      next_cycle();
    end
    wbValid = 1'b0;
    @(negedge clk);
    tests++; if (stallReq !== 1'b1) begin fails++; $display("FAIL starve_stall: got %0b want 1", stallReq); end
    tests++; if (we !== 1'b1 || writeRegister !== 5'd8 || writeData !== 32'h88) begin
      fails++; $display("FAIL starve_write8: got we=%0b r=%0d d=%h want 1/8/88", we, writeRegister, writeData); end
    tests++; if (busyMask !== 32'h100) begin fails++; $display("FAIL starve_busy_during: got %h want 100", busyMask); end
    next_cycle();
    @(negedge clk);
    tests++; if (stallReq !== 1'b0 || busyMask !== 32'h0 || we !== 1'b0) begin
      fails++; $display("FAIL starve_after: got stall=%0b busy=%h we=%0b want 0/0/0", stallReq, busyMask, we); end
    tests++; if (protocolErr !== 1'b0) begin fails++; $display("FAIL starve_perr_clean: got %0b want 0", protocolErr); end
    next_cycle();
    // Second round: the pipeline ignores the stall request.
    wbValid = 1'b1; wbReg = 5'd1;
    mdValid = 1'b1; mdReg = 5'd12; mdData = 32'hCC;
    next_cycle();
    mdValid = 1'b0;
    for (int i = 1; i <= 4; i++) next_cycle();
    wbReg = 5'd6; wbData = 32'h66;
    @(negedge clk);
    tests++; if (stallReq !== 1'b1) begin fails++; $display("FAIL perr_stall: got %0b want 1", stallReq); end
    tests++; if (we !== 1'b1 || writeRegister !== 5'd6 || writeData !== 32'h66) begin
      fails++; $display("FAIL perr_pipe_wins: got we=%0b r=%0d d=%h want 1/6/66", we, writeRegister, writeData); end
    next_cycle();
    wbValid = 1'b0;
    @(negedge clk);
    tests++; if (protocolErr !== 1'b1) begin fails++; $display("FAIL perr_set: got %0b want 1", protocolErr); end
    tests++; if (stallReq !== 1'b0) begin fails++; $display("FAIL perr_nostall: got %0b want 0", stallReq); end
    tests++; if (we !== 1'b1 || writeRegister !== 5'd12 || writeData !== 32'hCC) begin
      fails++; $display("FAIL perr_write12: got we=%0b r=%0d d=%h want 1/12/cc", we, writeRegister, writeData); end
    next_cycle();
    @(negedge clk);
    tests++; if (protocolErr !== 1'b1 || busyMask !== 32'h0) begin
      fails++; $display("FAIL perr_sticky: got perr=%0b busy=%h want 1/0", protocolErr, busyMask); end
    next_cycle();
  endtask

  task automatic test_idle_drain();
    wbValid = 1'b0;
    mdValid = 1'b1; mdReg = 5'd7; mdData = 32'd1;
    @(negedge clk);
    tests++; if (we !== 1'b0) begin fails++; $display("FAIL drain_nobypass: got %0b want 0", we); end
    next_cycle();
    mdReg = 5'd9; mdData = 32'd2;
    @(negedge clk);
    tests++; if (we !== 1'b1 || writeRegister !== 5'd7 || writeData !== 32'd1) begin
      fails++; $display("FAIL drain_first7: got we=%0b r=%0d d=%h want 1/7/1", we, writeRegister, writeData); end
    tests++; if (busyMask !== 32'h80) begin fails++; $display("FAIL drain_busy7: got %h want 80", busyMask); end
    next_cycle();
    mdValid = 1'b0;
    @(negedge clk);
    tests++; if (we !== 1'b1 || writeRegister !== 5'd9 || writeData !== 32'd2) begin
      fails++; $display("FAIL drain_second9: got we=%0b r=%0d d=%h want 1/9/2", we, writeRegister, writeData); end
    next_cycle();
    @(negedge clk);
    tests++; if (we !== 1'b0 || busyMask !== 32'h0 || stallReq !== 1'b0) begin
      fails++; $display("FAIL drain_idle: got we=%0b busy=%h stall=%0b want 0/0/0", we, busyMask, stallReq); end
    next_cycle();
  endtask

  task automatic test_reset_midop();
    wbValid = 1'b1; wbReg = 5'd1; wbData = 32'h1;
    mdValid = 1'b1; mdReg = 5'd3; mdData = 32'h33;
    next_cycle();
    mdReg = 5'd4; mdData = 32'h44;
    next_cycle();
    mdValid = 1'b0;
    @(negedge clk);
    tests++; if (busyMask !== 32'h18 || mdReady !== 1'b0) begin
      fails++; $display("FAIL midrst_queued: got busy=%h rdy=%0b want 18/0", busyMask, mdReady); end
    #2;
    rst = 1'b0; wbValid = 1'b0;
    #1;
    tests++; if (we !== 1'b0) begin fails++; $display("FAIL midrst_we: got %0b want 0", we); end
    tests++; if (mdReady !== 1'b1) begin fails++; $display("FAIL midrst_rdy: got %0b want 1", mdReady); end
    tests++; if (busyMask !== 32'h0) begin fails++; $display("FAIL midrst_busy: got %h want 0", busyMask); end
    tests++; if (stallReq !== 1'b0 || protocolErr !== 1'b0) begin
      fails++; $display("FAIL midrst_flags: got stall=%0b perr=%0b want 0/0", stallReq, protocolErr); end
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    tests++; if (we !== 1'b0) begin fails++; $display("FAIL midrst_discard: got %0b want 0", we); end
  endtask

  initial begin
    test_reset();
    test_pipeline();
    test_zero_drop();
    test_fill();
    test_starvation();
    test_idle_drain();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
